// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle LEGv8 subset core with req/ack instruction and data ports
// MULTICYCLE_CORE_CBNZ_EN: decode CBNZ; otherwise it is an illegal opcode and halts the core.
module multicycle_core #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [XLEN-1:0] startpc,
  output logic [XLEN-1:0] currentpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted
);

  localparam int RW = $clog2(NREG);
  localparam logic [RW-1:0] ZR = RW'(NREG - 1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR,
    OP_CBZ, OP_CBNZ, OP_B, OP_MOVZ, OP_ILL
  } op_t;

  state_t          state;
  op_t             op;
  op_t             op_dec;
  logic [31:0]     ir;
  logic [XLEN-1:0] opa, opb, imm, res, addr;
  logic [XLEN-1:0] imm_dec, rn_val, rm_val, rt_val;
  logic [63:0]     movz_wide;
  logic [RW-1:0]   rn_idx, rm_idx, rt_idx;
  logic [XLEN-1:0] regs [NREG];

  assign rn_idx = ir[5 +: RW];
  assign rm_idx = ir[16 +: RW];
  assign rt_idx = ir[0 +: RW];

  assign rn_val = (rn_idx == ZR) ? '0 : regs[rn_idx];
  assign rm_val = (rm_idx == ZR) ? '0 : regs[rm_idx];
  assign rt_val = (rt_idx == ZR) ? '0 : regs[rt_idx];

  always_comb begin
    op_dec = OP_ILL;
    if      (ir[31:21] == 11'b10001011000) op_dec = OP_ADD;
    else if (ir[31:21] == 11'b11001011000) op_dec = OP_SUB;
    else if (ir[31:21] == 11'b10001010000) op_dec = OP_AND;
    else if (ir[31:21] == 11'b10101010000) op_dec = OP_ORR;
    else if (ir[31:21] == 11'b11111000010) op_dec = OP_LDUR;
    else if (ir[31:21] == 11'b11111000000) op_dec = OP_STUR;
    else if (ir[31:24] == 8'b10110100)     op_dec = OP_CBZ;
`ifdef MULTICYCLE_CORE_CBNZ_EN
    else if (ir[31:24] == 8'b10110101)     op_dec = OP_CBNZ;
`endif
    else if (ir[31:26] == 6'b000101)       op_dec = OP_B;
    else if (ir[31:23] == 9'b110100101)    op_dec = OP_MOVZ;
  end

  // MOVZ is built at 64 bits so hw shifts past a 32-bit datapath truncate to zero.
  assign movz_wide = {48'b0, ir[20:5]} << {ir[22:21], 4'b0000};

  always_comb begin
    imm_dec = '0;
    case (op_dec)
      OP_LDUR, OP_STUR: imm_dec = {{(XLEN-9){ir[20]}}, ir[20:12]};
      OP_CBZ, OP_CBNZ:  imm_dec = {{(XLEN-21){ir[23]}}, ir[23:5], 2'b00};
      OP_B:             imm_dec = {{(XLEN-28){ir[25]}}, ir[25:0], 2'b00};
      OP_MOVZ:          imm_dec = movz_wide[XLEN-1:0];
      default:          imm_dec = '0;
    endcase
  end

  assign imem_req   = !resetl && (state == S_FETCH);
  assign imem_addr  = currentpc;
  assign dmem_req   = !resetl && (state == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_STUR);
  assign dmem_addr  = addr;
  assign dmem_wdata = opb;

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state     <= S_FETCH;
      currentpc <= startpc;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          op  <= op_dec;
          opa <= rn_val;
          opb <= (op_dec inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? rm_val : rt_val;
          imm <= imm_dec;
          if (op_dec == OP_ILL) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op)
            OP_ADD:  begin res <= opa + opb; state <= S_WB; end
            OP_SUB:  begin res <= opa - opb; state <= S_WB; end
            OP_AND:  begin res <= opa & opb; state <= S_WB; end
            OP_ORR:  begin res <= opa | opb; state <= S_WB; end
            OP_MOVZ: begin res <= imm;       state <= S_WB; end
            OP_LDUR, OP_STUR: begin
              addr  <= opa + imm;
              state <= S_MEM;
            end
            OP_CBZ: begin
              currentpc <= (opb == '0) ? currentpc + imm : currentpc + FOUR;
              retire    <= 1'b1;
              state     <= S_FETCH;
            end
            OP_CBNZ: begin
              currentpc <= (opb != '0) ? currentpc + imm : currentpc + FOUR;
              retire    <= 1'b1;
              state     <= S_FETCH;
            end
            OP_B: begin
              currentpc <= currentpc + imm;
              retire    <= 1'b1;
              state     <= S_FETCH;
            end
            default: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_STUR) begin
              currentpc <= currentpc + FOUR;
              retire    <= 1'b1;
              state     <= S_FETCH;
            end else begin
              res   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          currentpc <= currentpc + FOUR;
          retire    <= 1'b1;
          state     <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Register file is deliberately left unreset; only WB writes it.
  always_ff @(posedge CLK) begin
    if (!resetl && state == S_WB && rt_idx != ZR)
      regs[rt_idx] <= res;
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed bench for multicycle_core with variable-latency memory models
module tb_multicycle_core;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc, currentpc, imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [31:0] imem_rdata;

  logic [31:0] imem [256];
  logic [63:0] dmem [16];
  logic        imem_tie, d_block, d_force;
  int          i_lat, d_lat, icnt, dcnt;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  multicycle_core #(.XLEN(64), .NREG(32)) dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc), .currentpc(currentpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retire(retire), .halted(halted)
  );

  assign imem_rdata = imem[imem_addr[9:2]];
  assign imem_ack   = imem_tie | (imem_req & (icnt == i_lat));
  assign dmem_rdata = dmem[dmem_addr[6:3]];
  assign dmem_ack   = d_force | (dmem_req & !d_block & (dcnt == d_lat));

  // Ack arrives once a request has been held for *_lat extra cycles.
  always @(posedge CLK) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[6:3]] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_retire(input string tag, input int exp_cyc);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge CLK);
      n++;
      if (retire === 1'b1) seen = 1;
    end
    chk(tag, 64'(n), 64'(exp_cyc));
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {63'b0, halted}, 64'd1);
  endtask

  initial begin
    int r, q, n;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 64'h0;
    imem[64] = 32'hD28000A1;  // MOVZ X1,#5
    imem[65] = 32'hD2800062;  // MOVZ X2,#3
    imem[66] = 32'hCB020023;  // SUB X3,X1,X2
    imem[67] = 32'hD2800000;  // MOVZ X0,#0
    imem[68] = 32'hF8008003;  // STUR X3,[X0,#8]
    imem[69] = 32'hF8408004;  // LDUR X4,[X0,#8]
    imem[70] = 32'hF8010004;  // STUR X4,[X0,#16]
    imem[71] = 32'h14000002;  // B +2 -> 0x124
    imem[72] = 32'h14000003;  // B +3 -> 0x12C
    imem[73] = 32'hB4FFFFFF;  // CBZ XZR,-1 -> 0x120
    imem[75] = 32'hB4000081;  // CBZ X1,+4 (not taken)
    imem[76] = 32'hD28000E0;  // MOVZ X0,#7
    imem[77] = 32'hB5000040;  // CBNZ X0,+2
    imem[0]   = 32'h17FFFFFF; // B -1 -> wraps
    imem[255] = 32'hF84183E5; // LDUR X5,[XZR,#24]

    resetl = 1'b1; startpc = 64'h100; imem_tie = 1'b1; i_lat = 0; d_lat = 2;
    d_block = 1'b0; d_force = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pc", currentpc, 64'h100);
    chk("rst_imem_req", {63'b0, imem_req}, 64'd0);
    chk("rst_dmem_req", {63'b0, dmem_req}, 64'd0);
    chk("rst_retire", {63'b0, retire}, 64'd0);
    chk("rst_halted", {63'b0, halted}, 64'd0);

    resetl = 1'b0;
    #1;
    chk("first_imem_req", {63'b0, imem_req}, 64'd1);
    chk("first_imem_addr", imem_addr, 64'h100);

    wait_retire("movz1_cyc", 4);
    wait_retire("movz2_cyc", 4);
    wait_retire("sub_cyc", 4);
    chk("sub_pc", currentpc, 64'h10C);
    wait_retire("movz0_cyc", 4);

    // STUR: FETCH, DECODE, EXEC then three MEM cycles waiting on ack.
    repeat (3) @(negedge CLK);
    imem_tie = 1'b0; i_lat = 2;
    for (int j = 0; j < 3; j++) begin
      chk("stur_req", {63'b0, dmem_req}, 64'd1);
      chk("stur_we", {63'b0, dmem_we}, 64'd1);
      chk("stur_addr", dmem_addr, 64'd8);
      chk("stur_wdata", dmem_wdata, 64'd2);
      @(negedge CLK);
    end
    chk("stur_retire", {63'b0, retire}, 64'd1);
    chk("stur_req_drop", {63'b0, dmem_req}, 64'd0);
    chk("stur_pc", currentpc, 64'h114);
    chk("stur_mem", dmem[1], 64'd2);

    wait_retire("ldur_cyc", 9);
    wait_retire("stur2_cyc", 8);
    chk("ldur_value", dmem[2], 64'd2);
    wait_retire("b_fwd_cyc", 5);
    chk("b_fwd_pc", currentpc, 64'h124);
    wait_retire("cbz_taken_cyc", 5);
    chk("cbz_taken_pc", currentpc, 64'h120);
    wait_retire("b_fwd2_cyc", 5);
    chk("b_fwd2_pc", currentpc, 64'h12C);
    wait_retire("cbz_nt_cyc", 5);
    chk("cbz_nt_pc", currentpc, 64'h130);
    wait_retire("movz7_cyc", 6);
`ifdef MULTICYCLE_CORE_CBNZ_EN
    wait_retire("cbnz_cyc", 5);
    chk("cbnz_pc", currentpc, 64'h13C);
    wait_halt("illegal_halt");
    chk("halt_pc", currentpc, 64'h13C);
`else
    wait_halt("cbnz_illegal_halt");
    chk("halt_pc", currentpc, 64'h134);
`endif
    r = 0; q = 0;
    repeat (10) begin
      @(negedge CLK);
      r += int'(retire);
      q += int'(imem_req);
    end
    chk("halt_no_retire", 64'(r), 64'd0);
    chk("halt_no_fetch", 64'(q), 64'd0);
    chk("halt_stays", {63'b0, halted}, 64'd1);

    resetl = 1'b1; startpc = 64'h0; imem_tie = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst2_pc", currentpc, 64'h0);
    chk("rst2_halted", {63'b0, halted}, 64'd0);
    resetl = 1'b0;
    #1;
    chk("rst2_imem_addr", imem_addr, 64'h0);
    wait_retire("b_wrap_cyc", 3);
    chk("b_wrap_pc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Leave the load hanging, then reset while an ack arrives in the reset cycle.
    d_block = 1'b1;
    n = 0;
    while (dmem_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("hang_req", {63'b0, dmem_req}, 64'd1);
    chk("hang_addr", dmem_addr, 64'd24);
    @(negedge CLK);
    resetl = 1'b1; d_force = 1'b1;
    #1;
    chk("mid_rst_dmem_req", {63'b0, dmem_req}, 64'd0);
    chk("mid_rst_imem_req", {63'b0, imem_req}, 64'd0);
    @(negedge CLK);
    chk("mid_rst_pc", currentpc, 64'h0);
    resetl = 1'b0;
    #1;
    chk("restart_imem_addr", imem_addr, 64'h0);
    chk("restart_no_dmem", {63'b0, dmem_req}, 64'd0);
    wait_retire("restart_b_cyc", 3);
    chk("restart_b_pc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle LEGv8 processor. It executes a fixed LEGv8 subset through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memory are separate req/ack ports, so memory latency can vary. An illegal opcode stops the core in a HALT state. The block holds its own register file and ALU, and takes the place of the single-cycle top level in latency-tolerant systems.

## Interface
- XLEN, 64, datapath and register width (32 or 64).
- NREG, 32, register count (16 or 32). Register index is the low log2(NREG) bits of the 5-bit field. Register NREG-1 is the zero register.
- CLK  in  1  rising-edge clock.
- resetl  in  1  reset, synchronous, active-high.
- startpc  in  XLEN  PC loaded on reset.
- currentpc  out  XLEN  address of the instruction in progress.
- imem_req / imem_addr  out  1 / XLEN  instruction fetch request and address.
- imem_ack / imem_rdata  in  1 / 32  fetch acknowledge and instruction word.
- dmem_req / dmem_we  out  1 / 1  data request; 1 = store.
- dmem_addr / dmem_wdata  out  XLEN / XLEN  data address and store data.
- dmem_ack / dmem_rdata  in  1 / XLEN  data acknowledge and load data.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high while in HALT.

## Operation
**Supported instructions** (fields: Rd/Rt [4:0], Rn [9:5], Rm [20:16]):
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: Rd = Rn op Rm.
- LDUR 11111000010: Rt = mem[Rn + sext(imm9 [20:12])].
- STUR 11111000000: mem[Rn + sext(imm9)] = Rt.
- CBZ [31:24]=10110100: if Rt==0, PC += sext(imm19 [23:5])<<2.
- B [31:26]=000101: PC += sext(imm26)<<2.
- MOVZ [31:23]=110100101: Rd = imm16[20:5] << (16*hw[22:21]), truncated to XLEN.

**Arithmetic and registers**
- Arithmetic is modulo 2^XLEN.
- Branch targets wrap modulo 2^XLEN.
- The zero register reads 0; writes to it are discarded.
- Register file contents are not reset.

**State machine**
- FETCH: imem_req=1, imem_addr=currentpc. Stays until imem_ack; the IR is latched on the acknowledging edge. Then DECODE.
- DECODE: reads operands and sign-extends the immediate.
  - Illegal opcode → HALT.
  - Otherwise → EXEC.
- EXEC: computes the ALU result, address, or branch target.
  - B and CBZ: update PC, pulse retire, → FETCH.
  - LDUR/STUR → MEM.
  - All others → WB.
- MEM: dmem_req=1 with address held stable. dmem_we=1 for STUR, and dmem_wdata=Rt.
  - STUR: on dmem_ack, PC+=4, retire, → FETCH.
  - LDUR: on dmem_ack, captures dmem_rdata, → WB.
- WB: writes Rd, PC+=4, retire, → FETCH.
- HALT: halted=1, no requests. Only reset exits HALT.

## Timing
**Handshake**
- A request stays high with address and data stable until ack is sampled high on a rising edge.
- The request drops the following cycle because the state changes.
- An ack while req is low is ignored.

**Cycle counts** (k = FETCH cycles ≥1, m = MEM cycles ≥1)
- R-type and MOVZ: k+3.
- LDUR: k+m+3.
- STUR: k+m+2.
- B/CBZ: k+2.

**Reset**
- In any cycle with resetl=1, the next edge sets state=FETCH and currentpc=startpc. retire and halted clear.
- While resetl=1, imem_req, dmem_req and dmem_we are forced to 0.
- Reset in the middle of a transaction abandons it. Any ack arriving in the reset cycle is ignored.
- The first cycle after reset has imem_req=1 and imem_addr=startpc.

**Output reset values:** currentpc=startpc, retire=0, halted=0, all requests 0.

**Branches:** a taken CBZ uses the target. A not-taken CBZ uses PC+4. Both retire in EXEC.

## Configuration
- MULTICYCLE_CORE_CBNZ_EN defined: CBNZ ([31:24]=10110101) is decoded. It branches when Rt≠0, with the same timing as CBZ.
- MULTICYCLE_CORE_CBNZ_EN undefined: CBNZ is an illegal opcode → HALT, halted=1, no retire.

## Test plan
- Reset with startpc=0x100, imem_ack tied high → imem_addr=0x100 in the first cycle after reset. currentpc=0x100 during reset.
- MOVZ X1,#5 / MOVZ X2,#3 / SUB X3,X1,X2 with zero-wait memory → X3=2, retire every 4 cycles, PC reaches startpc+12.
- STUR X3,[X0,#8] then LDUR X4,[X0,#8] with dmem_ack delayed 3 cycles:
  - dmem_req is held high for 3 cycles with addr=8 stable and wdata=2.
  - X4=2.
  - The LDUR takes 9 cycles.
- CBZ on XZR with imm19=-1 → PC moves back by 4. CBZ on a nonzero register → PC+4. B with imm26=0x3FFFFFF at PC=0 → PC wraps to 2^XLEN-4.
- CBNZ word 0xB5000040 with a nonzero Rt:
  - Macro defined: branch of +8.
  - Macro undefined: halted=1, no further imem_req, no retire.
- Assert reset while MEM is waiting on dmem_ack → dmem_req=0 in that cycle. The core restarts at startpc. A late ack is ignored.
